// File: rtl/bpf_phase_ctrl.sv
// Instruction-phase sequencer for the BPF core: one-hot IF/ID/AL/EX/WB
// enables on the core clock, with wait states, halt, step, limit and faults.
module bpf_phase_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WAIT_W     = 4,
    parameter int MAX_WAIT   = 15,
    parameter int INSN_LIMIT = 4096
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iRUN,
    input  logic             iSTEP,
    input  logic             iCLR,
    input  logic             iMEM_RDY,
    input  logic             iRET,
    output logic             oEN_IF,
    output logic             oEN_ID,
    output logic             oEN_AL,
    output logic             oEN_EX,
    output logic             oEN_WB,
    output logic             oPC_INC,
    output logic             oBUSY,
    output logic             oHALTED,
    output logic             oFAULT,
    output logic [1:0]       oFAULT_CODE,
    output logic [CNT_W-1:0] oINSN_CNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_AL, S_EX, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(INSN_LIMIT);

    state_t             state;
    logic               run_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         code;

    logic               start;
    logic [CNT_W-1:0]   cnt_inc;
    logic               limit_hit;

    assign start     = iRUN & ~run_q;
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
    assign limit_hit = (cnt_inc == CNT_LIMIT);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= S_IDLE;
            run_q    <= 1'b0;
            wait_cnt <= '0;
            cnt      <= '0;
            code     <= 2'b00;
        end else begin
            run_q <= iRUN;
            if (iCLR) begin
                state    <= S_IDLE;
                wait_cnt <= '0;
                cnt      <= '0;
                code     <= 2'b00;
            end else begin
                unique case (state)
                    S_IDLE: if (start) state <= S_IF;
                    S_IF: begin
                        if (iMEM_RDY) begin
                            state    <= S_ID;
                            wait_cnt <= '0;
                        end else if (wait_cnt == WAIT_MAX) begin
                            state    <= S_FAULT;
                            wait_cnt <= '0;
                            code     <= 2'b01;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_ID: state <= S_AL;
                    S_AL: state <= S_EX;
                    S_EX: state <= S_WB;
                    S_WB: begin
                        cnt <= cnt_inc;
                        // RET wins over the limit when both land on one WB
                        if (iRET) begin
                            state <= S_HALT;
                        end else if (limit_hit) begin
                            state <= S_FAULT;
                            code  <= 2'b10;
                        end else if (iSTEP) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_IF;
                        end
                    end
                    S_HALT:  state <= S_HALT;
                    S_FAULT: state <= S_FAULT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign oEN_IF      = (state == S_IF);
    assign oEN_ID      = (state == S_ID);
    assign oEN_AL      = (state == S_AL);
    assign oEN_EX      = (state == S_EX);
    assign oEN_WB      = (state == S_WB);
    assign oPC_INC     = (state == S_WB) & ~iRET & ~limit_hit;
    assign oBUSY       = oEN_IF | oEN_ID | oEN_AL | oEN_EX | oEN_WB;
    assign oHALTED     = (state == S_HALT);
    assign oFAULT      = (state == S_FAULT);
    assign oFAULT_CODE = code;
    assign oINSN_CNT   = cnt;

endmodule

// File: tb/tb_bpf_phase_ctrl.sv
// Directed bench for bpf_phase_ctrl: default build plus a copy with a
// three-instruction limit, both driven by the same stimulus.
module tb_bpf_phase_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0, step = 1'b0, clr = 1'b0, rdy = 1'b0, ret = 1'b0;

    logic en_if, en_id, en_al, en_ex, en_wb, pc_inc, busy, halted, fault;
    logic [1:0]  fcode;
    logic [31:0] icnt;

    logic l_if, l_id, l_al, l_ex, l_wb, l_pc, l_busy, l_halt, l_fault;
    logic [1:0]  l_code;
    logic [31:0] l_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bpf_phase_ctrl dut (
        .iCLK(clk), .iRST(rst), .iRUN(run), .iSTEP(step), .iCLR(clr),
        .iMEM_RDY(rdy), .iRET(ret),
        .oEN_IF(en_if), .oEN_ID(en_id), .oEN_AL(en_al), .oEN_EX(en_ex),
        .oEN_WB(en_wb), .oPC_INC(pc_inc), .oBUSY(busy), .oHALTED(halted),
        .oFAULT(fault), .oFAULT_CODE(fcode), .oINSN_CNT(icnt)
    );

    bpf_phase_ctrl #(.INSN_LIMIT(3)) dut_lim (
        .iCLK(clk), .iRST(rst), .iRUN(run), .iSTEP(step), .iCLR(clr),
        .iMEM_RDY(rdy), .iRET(ret),
        .oEN_IF(l_if), .oEN_ID(l_id), .oEN_AL(l_al), .oEN_EX(l_ex),
        .oEN_WB(l_wb), .oPC_INC(l_pc), .oBUSY(l_busy), .oHALTED(l_halt),
        .oFAULT(l_fault), .oFAULT_CODE(l_code), .oINSN_CNT(l_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] en();
        return {en_if, en_id, en_al, en_ex, en_wb};
    endfunction

    function automatic logic [4:0] phase(input int p);
        logic [4:0] v;
        v = 5'b10000 >> p;
        return v;
    endfunction

    initial begin
        // reset state
        #2;
        check("rst_en", {27'd0, en()}, 0);
        check("rst_flags", {28'd0, pc_inc, busy, halted, fault}, 0);
        check("rst_cnt", icnt, 0);
        rst = 1'b1;
        tick();

        // free run, three instructions
        rdy = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("run_en%0d", i), {27'd0, en()}, {27'd0, phase(i % 5)});
            check($sformatf("run_pc%0d", i), {31'd0, pc_inc}, {31'd0, (i % 5) == 4});
            tick();
        end
        check("run_cnt3", icnt, 3);
        check("run_back_if", {31'd0, en_if}, 1);
        check("lim_fault10", {30'd0, l_code}, 2'b10);
        check("lim_faulted", {31'd0, l_fault}, 1);

        // three wait states then ready
        rdy = 1'b0;
        tick(); check("ws_if1", {31'd0, en_if}, 1);
        tick(); check("ws_if2", {31'd0, en_if}, 1);
        tick(); check("ws_if3", {31'd0, en_if}, 1);
        rdy = 1'b1;
        tick();
        check("ws_id", {27'd0, en()}, {27'd0, phase(1)});
        check("ws_nofault", {31'd0, fault}, 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_idle", {31'd0, busy}, 0);
        check("clr_cnt", icnt, 0);

        // memory timeout
        rdy = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("to_if%0d", i), {31'd0, en_if}, 1);
            tick();
        end
        check("to_fault", {31'd0, fault}, 1);
        check("to_code", {30'd0, fcode}, 2'b01);
        check("to_busy", {31'd0, busy}, 0);
        run = 1'b1;
        tick(); tick();
        check("to_sticky", {31'd0, fault}, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("to_clr_idle", {30'd0, busy, fault}, 0);
        check("to_clr_code", {30'd0, fcode}, 0);
        check("to_clr_cnt", icnt, 0);
        run = 1'b0;
        rdy = 1'b1;
        tick();

        // single step
        step = 1'b1;
        run = 1'b1;
        tick();
        check("st1_if", {31'd0, en_if}, 1);
        tick(); tick(); tick(); tick();
        check("st1_wb", {30'd0, en_wb, pc_inc}, 2'b11);
        tick();
        check("st1_idle", {31'd0, busy}, 0);
        check("st1_cnt", icnt, 1);
        tick(); tick();
        check("st1_held", {31'd0, busy}, 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        check("st2_if", {31'd0, en_if}, 1);
        tick(); tick(); tick(); tick();
        tick();
        check("st2_idle", {31'd0, busy}, 0);
        check("st2_cnt", icnt, 2);
        step = 1'b0;
        run = 1'b0;

        // RET on third WB, both limits
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("ret_wb", {31'd0, en_wb}, 1);
        ret = 1'b1;
        #1;
        check("ret_nopc", {31'd0, pc_inc}, 0);
        tick();
        ret = 1'b0;
        check("ret_halt", {30'd0, halted, busy}, 2'b10);
        check("ret_cnt", icnt, 3);
        check("lim_ret_halt", {30'd0, l_halt, l_fault}, 2'b10);

        // limit fault without RET
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("lim_wb_pc", {30'd0, l_wb, l_pc}, 2'b10);
        check("main_wb_pc", {31'd0, pc_inc}, 1);
        tick();
        check("lim_fault", {31'd0, l_fault}, 1);
        check("lim_code", {30'd0, l_code}, 2'b10);
        check("lim_cnt", l_cnt, 3);

        // async reset during AL
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        check("ar_al", {31'd0, en_al}, 1);
        rst = 1'b0;
        #1;
        check("ar_en", {27'd0, en()}, 0);
        check("ar_cnt", icnt, 0);
        check("ar_flags", {28'd0, pc_inc, busy, halted, fault}, 0);
        tick();
        rst = 1'b1;
        tick();

        // clear beats a simultaneous start
        clr = 1'b1;
        run = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_start", {31'd0, busy}, 0);
        tick();
        check("clr_start_hold", {31'd0, busy}, 0);
        run = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // single-phase property, checked every cycle
    always @(negedge clk) begin
        if (rst && ($countones(en()) > 1)) begin
            failures++;
            $display("FAIL onehot: got %b expected at most one bit", en());
        end
    end

endmodule

// File: doc/bpf_phase_ctrl.md
Name: bpf_phase_ctrl

Overview:
Instruction-phase sequencer for the BPF CPU core. It steps the core through IF, ID, AL, EX and WB, one phase per clock, and asserts exactly one one-hot phase enable at a time. It also handles instruction-memory wait states, halting on RET, single-step mode, an executed-instruction limit and fault reporting. It sits beside the cpu datapath and replaces free-running phase clocks with synchronous enables on the single core clock.

Parameters:
CNT_W, 32, width of the executed-instruction counter
WAIT_W, 4, width of the IF wait-state counter
MAX_WAIT, 15, maximum IF cycles spent waiting on iMEM_RDY before a fault
INSN_LIMIT, 4096, maximum instructions executed per run before a fault

Ports:
iCLK  in  1  core clock; all state updates on the rising edge
iRST  in  1  asynchronous, active-low reset
iRUN  in  1  run request; the rising edge starts execution from IDLE
iSTEP  in  1  single-step mode; when 1, return to IDLE after each WB
iCLR  in  1  synchronous clear/abort, level-sensitive
iMEM_RDY  in  1  instruction word valid; sampled in IF
iRET  in  1  current instruction is RET; from the decoder, sampled in WB
oEN_IF  out  1  fetch phase enable
oEN_ID  out  1  decode phase enable
oEN_AL  out  1  ALU phase enable
oEN_EX  out  1  execute/memory phase enable
oEN_WB  out  1  writeback phase enable
oPC_INC  out  1  one-cycle PC advance strobe
oBUSY  out  1  1 in any phase state (IF..WB)
oHALTED  out  1  1 in HALT
oFAULT  out  1  1 in FAULT
oFAULT_CODE  out  2  00 none, 01 memory timeout, 10 instruction limit
oINSN_CNT  out  CNT_W  instructions retired since the last clear

Behaviour:
- iRST=0, asynchronous: state=IDLE; all enables, oPC_INC, oBUSY, oHALTED and oFAULT = 0; oFAULT_CODE=00; oINSN_CNT=0; wait counter=0; run_q=0. Reset mid-instruction aborts immediately, with no partial WB.
- States: IDLE, IF, ID, AL, EX, WB, HALT, FAULT. Outputs are Moore: oEN_x=1 exactly in the cycles where state==x.
- start = iRUN & ~run_q. run_q is a register holding the previous-cycle iRUN. Holding iRUN high out of reset starts one run.
- IDLE: start -> IF. Latency: a start sampled at edge k gives oEN_IF=1 in the cycle after edge k.
- IF: if iMEM_RDY=1 -> ID and clear the wait counter.
  - Else increment the wait counter.
  - If iMEM_RDY=0 and the counter already equals MAX_WAIT -> FAULT with code 01.
  - Maximum time in IF is MAX_WAIT+1 cycles.
- ID -> AL -> EX -> WB: unconditional, 1 cycle each. Minimum instruction time is 5 cycles.
- WB: oINSN_CNT increments by 1, saturating at all-ones. Next state:
  - iRET=1 -> HALT. oPC_INC=0.
  - Else, if the incremented count equals INSN_LIMIT -> FAULT with code 10. oPC_INC=0.
  - Else oPC_INC=1 (combinational with state==WB & ~iRET & no-limit). Then iSTEP=1 -> IDLE, else -> IF.
- iRET has priority over the limit check in the same WB.
- HALT and FAULT are sticky: only iCLR or reset leaves them. iRUN is ignored there, but run_q still tracks iRUN.
- iCLR=1, any state, highest priority: next state IDLE; oINSN_CNT, wait counter and oFAULT_CODE cleared. Any pending start in that cycle is discarded.
- oINSN_CNT is not cleared by a new start from IDLE. Step and run accumulate until iCLR.
- Any reachable-state check must hold: at most one oEN_x is high in any cycle.

Test Plan:
- Release reset, iMEM_RDY=1, pulse iRUN, iRET=0 -> enables cycle IF,ID,AL,EX,WB repeating; oPC_INC high only in WB; oINSN_CNT=3 after 15 cycles in phase states.
- iMEM_RDY=0 for 3 cycles, then 1 -> IF lasts 4 cycles, then ID; no fault.
- iMEM_RDY held 0, MAX_WAIT=15 -> FAULT entered after 16 IF cycles; oFAULT_CODE=01; oBUSY=0; stays in FAULT until iCLR, then IDLE with count 0.
- iSTEP=1, iRUN held high -> exactly one instruction, back in IDLE, oINSN_CNT=1. Drop and raise iRUN -> second instruction, oINSN_CNT=2.
- iRET=1 on the 3rd WB -> HALT; oHALTED=1; oINSN_CNT=3; no oPC_INC in that WB. INSN_LIMIT=3 with iRET=0 gives FAULT code 10 at the 3rd WB. INSN_LIMIT=3 with iRET=1 on the 3rd WB gives HALT.
- Assert iRST=0 during AL -> all outputs 0 immediately. Assert iCLR and an iRUN rise in the same IDLE cycle -> stays IDLE.
